load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32E funct3 codes, FSM encoding and bus byte counts.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE    = 2'd0;
  localparam lsu_state_t ST_REQ     = 2'd1;
  localparam lsu_state_t ST_RELEASE = 2'd2;
  localparam lsu_state_t ST_DONE    = 2'd3;

  localparam logic [2:0] NB_NONE = 3'd0;
  localparam logic [2:0] NB_BYTE = 3'd1;
  localparam logic [2:0] NB_HALF = 3'd2;
  localparam logic [2:0] NB_WORD = 3'd4;

endpackage

// File: rtl/load_store_unit.sv
// Single-request load/store unit bridging the core to a start/done memory bus,
// with alignment checking, load extension and a bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 18,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_store,
  input  logic [2:0]              req_funct3,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_done,
  output logic                    rsp_err,
  output logic [31:0]             rsp_rdata,
  output logic [ADDRESS_SIZE-1:0] bus_address,
  output logic [2:0]              bus_num_bytes,
  output logic                    bus_is_write,
  output logic [31:0]             bus_write_value,
  output logic                    bus_start_request,
  input  logic                    bus_request_done,
  input  logic [31:0]             bus_fetched_value
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    funct3_q;
  logic          is_store_q;

  logic [2:0]  dec_nb;
  logic        dec_err;
  logic [31:0] dec_wv;
  logic [31:0] load_ext;

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    dec_nb  = NB_NONE;
    dec_err = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: dec_nb = NB_BYTE;
      F3_H, F3_HU: dec_nb = NB_HALF;
      F3_W:        dec_nb = NB_WORD;
      default:     dec_err = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (req_is_store && req_funct3 > F3_W) dec_err = 1'b1;
    if (dec_nb == NB_HALF && req_addr[0]) dec_err = 1'b1;
    if (dec_nb == NB_WORD && req_addr[1:0] != 2'b00) dec_err = 1'b1;

    case (dec_nb)
      NB_BYTE: dec_wv = {24'd0, req_wdata[7:0]};
      NB_HALF: dec_wv = {16'd0, req_wdata[15:0]};
      default: dec_wv = req_wdata;
    endcase
  end

  always_comb begin
    case (funct3_q)
      F3_B:    load_ext = {{24{bus_fetched_value[7]}}, bus_fetched_value[7:0]};
      F3_BU:   load_ext = {24'd0, bus_fetched_value[7:0]};
      F3_H:    load_ext = {{16{bus_fetched_value[15]}}, bus_fetched_value[15:0]};
      F3_HU:   load_ext = {16'd0, bus_fetched_value[15:0]};
      F3_W:    load_ext = bus_fetched_value;
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      tmo_cnt           <= '0;
      funct3_q          <= 3'd0;
      is_store_q        <= 1'b0;
      bus_start_request <= 1'b0;
      bus_is_write      <= 1'b0;
      bus_address       <= '0;
      bus_num_bytes     <= 3'd0;
      bus_write_value   <= 32'd0;
      rsp_done          <= 1'b0;
      rsp_err           <= 1'b0;
      rsp_rdata         <= 32'd0;
    end else begin
      rsp_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            is_store_q <= req_is_store;
            tmo_cnt    <= '0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= dec_err;
            if (dec_err) begin
              state    <= ST_DONE;
              rsp_done <= 1'b1;
            end else begin
              state             <= ST_REQ;
              bus_start_request <= 1'b1;
              bus_address       <= req_addr;
              bus_num_bytes     <= dec_nb;
              bus_is_write      <= req_is_store;
              bus_write_value   <= dec_wv;
            end
          end
        end
        ST_REQ: begin
          // A done arriving on the timeout cycle wins: it is checked first.
          if (bus_request_done) begin
            bus_start_request <= 1'b0;
            if (!is_store_q) rsp_rdata <= load_ext;
            state <= ST_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus_start_request <= 1'b0;
            rsp_err           <= 1'b1;
            state             <= ST_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!bus_request_done) begin
            state    <= ST_DONE;
            rsp_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases plus random ops against a spec-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done, rsp_err;
  logic [31:0] rsp_rdata;
  logic [17:0] bus_address;
  logic [2:0]  bus_num_bytes;
  logic        bus_is_write;
  logic [31:0] bus_write_value;
  logic        bus_start_request;
  logic        bus_request_done;
  logic [31:0] bus_fetched_value;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_SIZE(18), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus_address(bus_address), .bus_num_bytes(bus_num_bytes), .bus_is_write(bus_is_write),
    .bus_write_value(bus_write_value), .bus_start_request(bus_start_request),
    .bus_request_done(bus_request_done), .bus_fetched_value(bus_fetched_value)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size from funct3, alignment by modulo, extension by arithmetic.
  task automatic model(input bit st, input logic [2:0] f3, input logic [17:0] a,
                       input logic [31:0] wd, input logic [31:0] fe,
                       output bit err, output logic [31:0] rd,
                       output logic [2:0] nb, output logic [31:0] wv);
    int     size;
    longint mask, half, v;
    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    err  = (size == 0) || (st && f3 > 2) || (size != 0 && (int'(a) % size) != 0);
    nb   = 3'(size);
    mask = (64'd1 << (8 * size)) - 1;
    half = 64'd1 << (8 * size - 1);
    wv   = 32'(longint'(wd) & mask);
    v    = longint'(fe) & mask;
    if (f3 < 4 && size < 4 && v >= half) v = v - 2 * half;
    rd = (st || err) ? 32'd0 : 32'(v);
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [17:0] a,
                       input logic [31:0] wd, input logic [31:0] fe,
                       input int delay, input int hold, input bit hang);
    bit          m_err;
    logic [31:0] m_rd, m_wv;
    logic [2:0]  m_nb;
    int          to, bad, pulses, cnt;
    model(st, f3, a, wd, fe, m_err, m_rd, m_nb, m_wv);
    if (hang && !m_err) m_rd = 32'd0;
    bus_fetched_value = fe;
    to = 0;
    while (!req_ready && to < 50) begin step(); to++; end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 18'($urandom); req_wdata = $urandom;
    pulses = 0;
    if (m_err) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus_start_request) bad++;
        if (rsp_done) begin
          pulses++;
          check("err_latency", 32'(i <= 1), 32'd1);
          check("err_flag", 32'(rsp_err), 32'd1);
          check("err_rdata", rsp_rdata, 32'd0);
        end
        step();
      end
      check("err_nostart", 32'(bad), 32'd0);
      check("err_pulses", 32'(pulses), 32'd1);
      return;
    end
    check("start_rise", 32'(bus_start_request), 32'd1);
    check("bus_addr", 32'(bus_address), 32'(a));
    check("bus_nbytes", 32'(bus_num_bytes), 32'(m_nb));
    check("bus_iswrite", 32'(bus_is_write), 32'(st));
    check("bus_wvalue", bus_write_value, m_wv);
    if (hang) begin
      cnt = 1;
      while (cnt < 1100) begin
        step();
        if (bus_start_request) cnt++; else break;
      end
      check("tmo_cycles", 32'(cnt), 32'd1023);
    end else begin
      bad = 0;
      for (int i = 0; i < delay; i++) begin
        step();
        if (!bus_start_request || bus_address !== a || bus_write_value !== m_wv) bad++;
      end
      check("start_stable", 32'(bad), 32'd0);
      bus_request_done = 1'b1;
      step();
      check("start_drop", 32'(bus_start_request), 32'd0);
      for (int i = 0; i < hold; i++) begin
        if (rsp_done) pulses++;
        step();
      end
      if (rsp_done) pulses++;
      check("release_wait", 32'(pulses), 32'd0);
      bus_request_done = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_done) begin
        pulses++;
        check("rsp_err", 32'(rsp_err), 32'(hang));
        check("rsp_rdata", rsp_rdata, m_rd);
      end
    end
    check("done_pulses", 32'(pulses), 32'd1);
    step();
    check("rdata_hold", rsp_rdata, m_rd);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 18'd0; req_wdata = 32'd0; bus_request_done = 1'b0; bus_fetched_value = 32'd0;
    step(); step();
    check("rst_start", 32'(bus_start_request), 32'd0);
    check("rst_addr", 32'(bus_address), 32'd0);
    check("rst_wvalue", bus_write_value, 32'd0);
    check("rst_rsp", {29'd0, rsp_done, rsp_err, bus_is_write}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    step();

    do_op(1'b0, 3'd2, 18'h00010, 32'd0, 32'hDEADBEEF, 40, 1, 1'b0);
    do_op(1'b0, 3'd0, 18'h00003, 32'd0, 32'h00000080, 3, 0, 1'b0);
    do_op(1'b0, 3'd4, 18'h00003, 32'd0, 32'h00000080, 3, 2, 1'b0);
    do_op(1'b1, 3'd1, 18'h20002, 32'h12345678, 32'hFFFFFFFF, 5, 0, 1'b0);
    do_op(1'b0, 3'd2, 18'h00006, 32'd0, 32'h11111111, 0, 0, 1'b0);
    do_op(1'b1, 3'd4, 18'h00004, 32'hCAFEF00D, 32'd0, 0, 0, 1'b0);
    do_op(1'b0, 3'd2, 18'h00020, 32'd0, 32'h55AA55AA, 0, 0, 1'b1);

    // Reset while the bus request is outstanding.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 18'h00040;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midrst_busy", 32'(bus_start_request), 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_start", 32'(bus_start_request), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    step();
    do_op(1'b0, 3'd2, 18'h00044, 32'd0, 32'h0BADF00D, 7, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [17:0] ra;
      ra = 18'($urandom);
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_op(1'($urandom), 3'($urandom), ra, $urandom, $urandom,
            int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
